// File: rtl/seq_mag_comparator.sv
// Multi-cycle magnitude comparator: walks DIGIT bits per clock from the MSB and stops at the first unequal digit.
// Optional SIGNED_CMP_EN: treat operands as two's complement by flipping the MSB as they are latched.

module seq_mag_comparator #(
  parameter  int WIDTH = 8,
  parameter  int DIGIT = 2,
  localparam int NDIG  = WIDTH / DIGIT,
  localparam int CW    = $clog2(NDIG + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_eq_b,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic [CW-1:0]    cycles
);

  // state  | meaning
  // IDLE   | waiting for start, last result held
  // CMP    | comparing digit idx, one digit per clock
  // DONE   | one-cycle done pulse, start accepted here too
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

`ifdef SIGNED_CMP_EN
  localparam logic [WIDTH-1:0] SGN_MASK = WIDTH'(1) << (WIDTH - 1);
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic [CW-1:0]    cycles_q, cycles_d;
  logic [DIGIT-1:0] dig_a, dig_b;

  assign dig_a = a_q[int'(idx_q) * DIGIT +: DIGIT];
  assign dig_b = b_q[int'(idx_q) * DIGIT +: DIGIT];

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    eq_d     = eq_q;
    gt_d     = gt_q;
    lt_d     = lt_q;
    cycles_d = cycles_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
`ifdef SIGNED_CMP_EN
          a_d = a ^ SGN_MASK;
          b_d = b ^ SGN_MASK;
`else
          a_d = a;
          b_d = b;
`endif
          idx_d    = IW'(NDIG - 1);
          eq_d     = 1'b0;
          gt_d     = 1'b0;
          lt_d     = 1'b0;
          cycles_d = '0;
          state_d  = S_CMP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CMP: begin
        cycles_d = cycles_q + CW'(1);
        if (dig_a > dig_b) begin
          gt_d    = 1'b1;
          state_d = S_DONE;
        end else if (dig_a < dig_b) begin
          lt_d    = 1'b1;
          state_d = S_DONE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      eq_q     <= 1'b0;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      eq_q     <= eq_d;
      gt_q     <= gt_d;
      lt_q     <= lt_d;
      cycles_q <= cycles_d;
    end
  end

  assign busy   = (state_q == S_CMP);
  assign done   = (state_q == S_DONE);
  assign a_eq_b = eq_q;
  assign a_gt_b = gt_q;
  assign a_lt_b = lt_q;
  assign cycles = cycles_q;

endmodule

// File: doc/seq_mag_comparator.md
Name: seq_mag_comparator

Overview:
Parametrised, multi-cycle magnitude comparator for two WIDTH-bit operands. It examines DIGIT bits per clock, most significant digit first, and stops early at the first unequal digit. Results are flag-compatible with the combinational 2-bit comparator (eq/gt/lt, exactly one high), and a start/busy/done handshake is added. Used where wide compares must not sit on a single-cycle critical path.

Parameters:
WIDTH, 8, operand width in bits; must be an integer multiple of DIGIT.
DIGIT, 2, bits compared per clock cycle; 1 <= DIGIT <= WIDTH.
NDIG (localparam), WIDTH/DIGIT, number of digits.
CW (localparam), $clog2(NDIG+1), width of the cycle counter.

Ports:
clk     input   1      rising-edge clock
rst     input   1      asynchronous, active-high reset
start   input   1      request a compare; sampled only when busy=0
a       input   WIDTH  operand A; sampled on the accepted start edge only
b       input   WIDTH  operand B; sampled on the accepted start edge only
busy    output  1      high while in state CMP
done    output  1      one-cycle pulse; results valid from this cycle on
a_eq_b  output  1      A == B
a_gt_b  output  1      A > B
a_lt_b  output  1      A < B
cycles  output  CW     number of digits examined in the last compare (1..NDIG)

Behaviour:
- Reset (async, rst=1): state=IDLE. busy, done, a_eq_b, a_gt_b, a_lt_b = 0. cycles=0. Operand registers = 0.
- States: IDLE, CMP, DONE. busy=1 only in CMP. done=1 only in DONE.
- IDLE/DONE with start=1 at an edge:
  - latch a and b;
  - digit index idx = NDIG-1;
  - clear all three flags;
  - cycles = 0;
  - go to CMP.
- IDLE/DONE with start=0: DONE -> IDLE, and IDLE stays in IDLE. Flags and cycles hold.
- start while busy=1 is ignored. Operands are not resampled and there is no queuing.
- CMP, each edge: compare digit idx (bits [idx*DIGIT+DIGIT-1 : idx*DIGIT]) as unsigned; cycles increments by 1.
  - Digit A > digit B: a_gt_b=1, go to DONE.
  - Digit A < digit B: a_lt_b=1, go to DONE.
  - Digits equal and idx==0: a_eq_b=1, go to DONE.
  - Digits equal and idx>0: idx decrements, stay in CMP.
- Latency: start accepted at edge E. done is high during the cycle after edge E+n, where n = cycles (1..NDIG). Worst case is NDIG+1 edges from start to done.
- Flags and cycles are updated on the same edge that enters DONE. They hold until the next accepted start or reset. After any done, exactly one flag is high.
- Back-to-back: start=1 during the DONE cycle is accepted, so done pulses are separated by n+1 cycles minimum.
- Reset mid-CMP: immediate return to reset values. No done pulse is produced.
- Degenerate case DIGIT=WIDTH: every compare takes exactly 1 CMP cycle, and cycles=1.

Optional Feature:
Macro SIGNED_CMP_EN.
- Defined: operands are two's complement. The MSB of both a and b is inverted when latched, so the ordinary unsigned digit compare yields the signed result. Flags and cycles semantics are unchanged.
- Undefined: operands are unsigned. No inversion logic is present.

Test Plan (WIDTH=8, DIGIT=2, NDIG=4):
1. Reset then idle -> all outputs 0. Pulse rst=1 during CMP of a compare -> outputs 0 immediately, no done pulse.
2. a=8'hA5, b=8'hA5, start -> busy for 4 cycles, then done=1 with a_eq_b=1, a_gt_b=0, a_lt_b=0, cycles=4.
3. a=8'hC0, b=8'h3F -> early exit after 1 CMP cycle: a_gt_b=1, cycles=1. Then a=8'h12, b=8'h13 -> a_lt_b=1, cycles=4.
4. Assert start with a=8'h00, b=8'hFF while busy=1 -> ignored; the in-flight result is unchanged. start=1 in the DONE cycle -> accepted, new compare begins on that edge.
5. a=8'h80, b=8'h01 -> a_gt_b=1, cycles=1 without SIGNED_CMP_EN; a_lt_b=1, cycles=1 with SIGNED_CMP_EN defined.
6. Exhaustive: all 65536 a/b pairs, checked against a ? : reference model after each done. Also check one-hot flags and cycles = (index of first differing digit from the MSB)+1, or 4 when a==b.
